// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared execute-stage types for the ALU and the iterative multiply/divide unit.
package muldiv_unit_pkg;
  typedef logic [4:0] t_register_index;
  typedef enum logic [3:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
    ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLT, ALU_OP_SLTU
  } t_alu_operation;
  typedef enum logic [3:0] {
    MULDIV_OP_INVALID, MULDIV_OP_MUL, MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU,
    MULDIV_OP_DIV, MULDIV_OP_DIVU, MULDIV_OP_REM, MULDIV_OP_REMU
  } t_muldiv_operation;
  typedef enum logic [1:0] {MULDIV_IDLE, MULDIV_BUSY, MULDIV_DONE} t_muldiv_state;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: 2*XLEN accumulator with one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0] sum, cand, diff;
  always_comb begin
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    cand = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff = cand - {1'b0, b_q};
    acc_d = acc_q;
    b_d = b_q;
    if (load) begin
      acc_d = {{XLEN{1'b0}}, a};
      b_d = b;
    end else if (step) begin
      // divide: remainder in the high half, quotient bits shift into the low half; diff[XLEN] is the borrow
      acc_d = is_div ? (diff[XLEN] ? {cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                     : (acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]});
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q <= b_d;
    end
  end
  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready handshake, single-cycle special cases and rd tag pass-through.
module muldiv_unit import muldiv_unit_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  t_muldiv_operation in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  t_register_index   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output t_register_index   out_rd
);
  localparam int CW = $clog2(XLEN + 1);
  t_muldiv_state state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  t_muldiv_operation op_q, op_d;
  t_register_index rd_q, rd_d;
  logic neg_q, neg_d;
  logic [XLEN-1:0] res_q, res_d;
  logic load, step, is_div_in, is_rem_in, sign_a, sign_b, neg_a, neg_b, b_zero, ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res, hi, lo, mul_hi, fix;
  always_comb begin
    is_div_in = in_op inside {MULDIV_OP_DIV, MULDIV_OP_DIVU, MULDIV_OP_REM, MULDIV_OP_REMU};
    is_rem_in = in_op inside {MULDIV_OP_REM, MULDIV_OP_REMU};
    sign_a = in_op inside {MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_DIV, MULDIV_OP_REM};
    sign_b = in_op inside {MULDIV_OP_MULH, MULDIV_OP_DIV, MULDIV_OP_REM};
    neg_a = sign_a & in_a[XLEN-1];
    neg_b = sign_b & in_b[XLEN-1];
    a_mag = neg_a ? -in_a : in_a;
    b_mag = neg_b ? -in_b : in_b;
    b_zero = is_div_in && in_b == '0;
    ovf = in_op inside {MULDIV_OP_DIV, MULDIV_OP_REM} && in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1;
    fast = in_op == MULDIV_OP_INVALID || b_zero || ovf;
    fast_res = b_zero ? (is_rem_in ? in_a : '1) : (ovf && in_op == MULDIV_OP_DIV) ? in_a : '0;
    // high half of a negated 2*XLEN product: invert, carry in only when the low half is zero
    mul_hi = neg_q ? ~hi + {{(XLEN-1){1'b0}}, lo == '0} : hi;
    fix = op_q == MULDIV_OP_MUL ? lo
        : op_q inside {MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU} ? mul_hi
        : op_q inside {MULDIV_OP_DIV, MULDIV_OP_DIVU} ? (neg_q ? -lo : lo)
        : (neg_q ? -hi : hi);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    rd_d = rd_q;
    neg_d = neg_q;
    res_d = res_q;
    load = 1'b0;
    step = 1'b0;
    if (flush) state_d = MULDIV_IDLE;
    else if (state_q == MULDIV_IDLE && in_valid) begin
      load = 1'b1;
      op_d = in_op;
      rd_d = in_rd;
      neg_d = is_rem_in ? neg_a : neg_a ^ neg_b;
      cnt_d = fast ? '0 : CW'(XLEN);
      res_d = fast ? fast_res : res_q;
      state_d = fast ? MULDIV_DONE : MULDIV_BUSY;
    end else if (state_q == MULDIV_BUSY) begin
      if (cnt_q == '0) begin
        res_d = fix;
        state_d = MULDIV_DONE;
      end else begin
        step = 1'b1;
        cnt_d = cnt_q - CW'(1);
      end
    end else if (state_q == MULDIV_DONE && out_ready) state_d = MULDIV_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MULDIV_IDLE;
      cnt_q <= '0;
      op_q <= MULDIV_OP_INVALID;
      rd_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      rd_q <= rd_d;
      neg_q <= neg_d;
      res_q <= res_d;
    end
  end
  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step),
    .is_div(op_q inside {MULDIV_OP_DIV, MULDIV_OP_DIVU, MULDIV_OP_REM, MULDIV_OP_REMU}),
    .a(a_mag), .b(b_mag), .hi(hi), .lo(lo)
  );
  assign in_ready = state_q == MULDIV_IDLE;
  assign out_valid = state_q == MULDIV_DONE;
  assign out_result = res_q;
  assign out_rd = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  t_muldiv_operation in_op = MULDIV_OP_INVALID;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  t_register_index in_rd = '0, out_rd;
  int checks = 0, errors = 0;
  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model(t_muldiv_operation op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    p = '0;
    case (op)
      MULDIV_OP_MUL:    begin p = ua * ub; return p[31:0]; end
      MULDIV_OP_MULH:   begin p = sa * sb; return p[63:32]; end
      MULDIV_OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      MULDIV_OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      MULDIV_OP_DIV:    return b == 0 ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
      MULDIV_OP_REM:    return b == 0 ? a : ov ? 32'h0 : 32'(sa % sb);
      MULDIV_OP_DIVU:   return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
      MULDIV_OP_REMU:   return b == 0 ? a : 32'(ua % ub);
      default:          return 32'h0;
    endcase
  endfunction
  function automatic int model_lat(t_muldiv_operation op, logic [31:0] a, logic [31:0] b);
    if (op == MULDIV_OP_INVALID) return 0;
    if (op inside {MULDIV_OP_DIV, MULDIV_OP_DIVU, MULDIV_OP_REM, MULDIV_OP_REMU} && b == 0) return 0;
    if (op inside {MULDIV_OP_DIV, MULDIV_OP_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  // lat counts edges after the accept edge until out_valid is seen; rdy is in_ready after the handshake edge
  task automatic run_op(input t_muldiv_operation op, input logic [31:0] a, input logic [31:0] b,
                        input t_register_index rd, output logic [31:0] res, output t_register_index ro,
                        output int lat, output logic rdy);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    ro = out_rd;
    @(posedge clk); #1;
    rdy = in_ready && !out_valid;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'h0 || out_rd !== 5'h0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b result=%h rd=%0d expected 1 0 0 0", in_ready, out_valid, out_result, out_rd);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
  typedef struct { t_muldiv_operation op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat; } t_vec;
  task automatic test_directed();
    t_vec v[14];
    logic [31:0] res; t_register_index ro; int lat; logic rdy;
    v[0]  = '{MULDIV_OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    v[1]  = '{MULDIV_OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    v[2]  = '{MULDIV_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    v[3]  = '{MULDIV_OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    v[4]  = '{MULDIV_OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    v[5]  = '{MULDIV_OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    v[6]  = '{MULDIV_OP_DIVU,   32'd100,        32'd7,         32'd14,        33};
    v[7]  = '{MULDIV_OP_REMU,   32'd100,        32'd7,         32'd2,         33};
    v[8]  = '{MULDIV_OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 0};
    v[9]  = '{MULDIV_OP_REM,    32'd5,          32'd0,         32'd5,         0};
    v[10] = '{MULDIV_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0};
    v[11] = '{MULDIV_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         0};
    v[12] = '{MULDIV_OP_INVALID,32'd123,        32'd456,       32'h0,         0};
    v[13] = '{MULDIV_OP_REMU,   32'd9,          32'd0,         32'd9,         0};
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 5), res, ro, lat, rdy);
      checks++;
      if (res !== v[i].exp || ro !== 5'(i + 5) || lat != v[i].lat || rdy !== 1'b1) begin
        errors++;
        $display("FAIL directed[%0d] %s: result=%h rd=%0d lat=%0d ready_after=%b expected %h %0d %0d 1",
                 i, v[i].op.name(), res, ro, lat, rdy, v[i].exp, i + 5, v[i].lat);
      end
    end
  endtask
  task automatic test_random();
    logic [31:0] a, b, res; t_register_index rd, ro; int lat; logic rdy; t_muldiv_operation op;
    for (int i = 0; i < 60; i++) begin
      op = t_muldiv_operation'($urandom_range(0, 8));
      a = pick(); b = pick(); rd = 5'($urandom);
      run_op(op, a, b, rd, res, ro, lat, rdy);
      checks++;
      if (res !== model(op, a, b) || ro !== rd || lat != model_lat(op, a, b) || rdy !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] %s a=%h b=%h: result=%h rd=%0d lat=%0d ready_after=%b expected %h %0d %0d 1",
                 i, op.name(), a, b, res, ro, lat, rdy, model(op, a, b), rd, model_lat(op, a, b));
      end
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] exp; int lat;
    exp = model(MULDIV_OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = MULDIV_OP_MULHU; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_rd = 5'd17;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp || out_rd !== 5'd17 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b result=%h rd=%0d ready=%b expected 1 %h 17 0",
                 i, out_valid, out_result, out_rd, in_ready, exp);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask
  task automatic watch_quiet(input string name);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s_quiet: out_valid high %0d cycles expected 0", name, seen);
    end
  endtask
  task automatic test_flush();
    logic [31:0] res; t_register_index ro; int lat; logic rdy;
    @(negedge clk);
    in_valid = 1'b1; in_op = MULDIV_OP_DIV; in_a = 32'd1000; in_b = 32'd7; in_rd = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    watch_quiet("flush_busy");
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = MULDIV_OP_DIVU; in_a = 32'd9; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_beats_valid: ready=%b expected 1", in_ready);
    end
    watch_quiet("flush_accept");
    run_op(MULDIV_OP_DIVU, 32'd9, 32'd3, 5'd9, res, ro, lat, rdy);
    checks++;
    if (res !== 32'd3 || ro !== 5'd9 || lat != 33) begin
      errors++;
      $display("FAIL after_flush DIVU: result=%h rd=%0d lat=%0d expected 3 9 33", res, ro, lat);
    end
  endtask
  task automatic test_reset_mid();
    logic [31:0] res; t_register_index ro; int lat; logic rdy;
    @(negedge clk);
    in_valid = 1'b1; in_op = MULDIV_OP_MUL; in_a = 32'd12345; in_b = 32'd678; in_rd = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b rd=%0d expected 1 0 0", in_ready, out_valid, out_rd);
    end
    @(negedge clk) rst_n = 1'b1;
    watch_quiet("reset_mid");
    run_op(MULDIV_OP_DIVU, 32'd9, 32'd3, 5'd11, res, ro, lat, rdy);
    checks++;
    if (res !== 32'd3 || ro !== 5'd11 || lat != 33 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL after_reset DIVU: result=%h rd=%0d lat=%0d ready_after=%b expected 3 11 33 1", res, ro, lat, rdy);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
